// File: rtl/axils_wr_ch_if.sv
// ----------------------------------------------------------------------------
// axils_wr_ch_if
// AXI4-Lite write-side bundle: write address (AW), write data (W) and write
// response (B) channels.
//
// Signals:
//   AWADDR[31:0], AWPROT[2:0], AWVALID   master -> slave
//   AWREADY                              slave  -> master
//   WDATA[31:0], WSTRB[3:0], WVALID      master -> slave
//   WREADY                               slave  -> master
//   BVALID, BRESP[1:0]                   slave  -> master
//   BREADY                               master -> slave
// ----------------------------------------------------------------------------
interface axils_wr_ch_if;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;

    modport master (
        output AWADDR, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BVALID, BRESP,
        output BREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BVALID, BRESP,
        input  BREADY
    );
endinterface

// File: rtl/axils_wr_ch.sv
// ----------------------------------------------------------------------------
// axils_wr_ch
// AXI4-Lite write channel slave that turns one AXI write at a time into a
// held local register write request (REG_WEN ... REG_ACK) and returns the
// outcome on the B channel. Addresses outside the decoded window get DECERR,
// all-zero strobes complete with OKAY without touching the local bus, and a
// local write that is not acknowledged within ACK_TIMEOUT cycles gets SLVERR.
//
// Parameters:
//   BASE_ADDR    base of the decoded byte window (aligned to 2^ADDR_BITS)
//   ADDR_BITS    log2 of the window size in bytes (3..31)
//   ACK_TIMEOUT  maximum REG_WEN cycles without REG_ACK (1..65535)
//
// Ports:
//   ACLK         rising-edge clock
//   ARESETn      synchronous active-low reset
//   axi          AXI4-Lite AW/W/B channels (slave modport)
//   REG_WEN      local write request, held until acknowledged or timed out
//   REG_ADDR     local byte address, word aligned
//   REG_WDATA    local write data
//   REG_WSTRB    local byte enables
//   REG_ACK      local write done (only meaningful while REG_WEN is high)
//   REG_ERR      error qualifier sampled together with REG_ACK
// ----------------------------------------------------------------------------
module axils_wr_ch #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_BITS   = 12,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axils_wr_ch_if.slave         axi,
    output logic                 REG_WEN,
    output logic [ADDR_BITS-1:0] REG_ADDR,
    output logic [31:0]          REG_WDATA,
    output logic [3:0]           REG_WSTRB,
    input  logic                 REG_ACK,
    input  logic                 REG_ERR
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RESP
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    state_t                 r_state,     w_state_nxt;
    logic                   r_aw_held,   w_aw_held_nxt;
    logic                   r_w_held,    w_w_held_nxt;
    logic                   r_hit,       w_hit_nxt;
    logic                   r_bvalid,    w_bvalid_nxt;
    logic [1:0]             r_bresp,     w_bresp_nxt;
    logic                   r_reg_wen,   w_reg_wen_nxt;
    logic [ADDR_BITS-1:0]   r_reg_addr,  w_reg_addr_nxt;
    logic [31:0]            r_reg_wdata, w_reg_wdata_nxt;
    logic [3:0]             r_reg_wstrb, w_reg_wstrb_nxt;
    logic [15:0]            r_cnt,       w_cnt_nxt;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_awaddr_hit;
    logic                   w_hit_now;
    logic [3:0]             w_strb_now;
    logic                   w_both;
    logic                   w_unused_awprot;

    // Protection bits carry no meaning for this register space.
    assign w_unused_awprot = &{1'b0, axi.AWPROT};

    assign axi.AWREADY = (r_state == IDLE) && !r_aw_held;
    assign axi.WREADY  = (r_state == IDLE) && !r_w_held;
    assign axi.BVALID  = r_bvalid;
    assign axi.BRESP   = r_bresp;

    assign REG_WEN   = r_reg_wen;
    assign REG_ADDR  = r_reg_addr;
    assign REG_WDATA = r_reg_wdata;
    assign REG_WSTRB = r_reg_wstrb;

    assign w_aw_hs = axi.AWVALID && axi.AWREADY;
    assign w_w_hs  = axi.WVALID  && axi.WREADY;

    // Window decode is done when the address arrives and kept in r_hit, so the
    // full 32-bit address never has to be stored.
    assign w_awaddr_hit = (axi.AWADDR >> ADDR_BITS) == (BASE_ADDR >> ADDR_BITS);

    // The decision uses the value arriving this cycle when a handshake is
    // completing, otherwise the value captured earlier.
    assign w_hit_now  = w_aw_hs ? w_awaddr_hit : r_hit;
    assign w_strb_now = w_w_hs  ? axi.WSTRB    : r_reg_wstrb;
    assign w_both     = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state     <= IDLE;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_hit       <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bresp     <= 2'b00;
            r_reg_wen   <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= 32'h0;
            r_reg_wstrb <= 4'h0;
            r_cnt       <= 16'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_aw_held   <= w_aw_held_nxt;
            r_w_held    <= w_w_held_nxt;
            r_hit       <= w_hit_nxt;
            r_bvalid    <= w_bvalid_nxt;
            r_bresp     <= w_bresp_nxt;
            r_reg_wen   <= w_reg_wen_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            r_reg_wstrb <= w_reg_wstrb_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Address and data are captured straight into the local-bus output
    // registers; they cannot change again until the B handshake, so they stay
    // stable for the whole time REG_WEN is high.
    always_comb begin
        w_state_nxt     = r_state;
        w_aw_held_nxt   = r_aw_held;
        w_w_held_nxt    = r_w_held;
        w_hit_nxt       = r_hit;
        w_bvalid_nxt    = r_bvalid;
        w_bresp_nxt     = r_bresp;
        w_reg_wen_nxt   = r_reg_wen;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_reg_wstrb_nxt = r_reg_wstrb;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            IDLE: begin
                if (w_aw_hs) begin
                    w_aw_held_nxt  = 1'b1;
                    w_hit_nxt      = w_awaddr_hit;
                    w_reg_addr_nxt = {axi.AWADDR[ADDR_BITS-1:2], 2'b00};
                end
                if (w_w_hs) begin
                    w_w_held_nxt    = 1'b1;
                    w_reg_wdata_nxt = axi.WDATA;
                    w_reg_wstrb_nxt = axi.WSTRB;
                end
                if (w_both) begin
                    if (!w_hit_now) begin
                        w_state_nxt  = RESP;
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = 2'b11;
                    end else if (w_strb_now == 4'h0) begin
                        w_state_nxt  = RESP;
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = 2'b00;
                    end else begin
                        w_state_nxt   = WRITE;
                        w_reg_wen_nxt = 1'b1;
                        w_cnt_nxt     = 16'h0;
                    end
                end
            end

            // An acknowledge on the expiry cycle still wins over the timeout.
            WRITE: begin
                if (REG_ACK) begin
                    w_state_nxt   = RESP;
                    w_reg_wen_nxt = 1'b0;
                    w_bvalid_nxt  = 1'b1;
                    w_bresp_nxt   = REG_ERR ? 2'b10 : 2'b00;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                    if (r_cnt == TIMEOUT_LAST) begin
                        w_state_nxt   = RESP;
                        w_reg_wen_nxt = 1'b0;
                        w_bvalid_nxt  = 1'b1;
                        w_bresp_nxt   = 2'b10;
                    end
                end
            end

            RESP: begin
                if (axi.BREADY) begin
                    w_state_nxt   = IDLE;
                    w_bvalid_nxt  = 1'b0;
                    w_aw_held_nxt = 1'b0;
                    w_w_held_nxt  = 1'b0;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axils_wr_ch.sv
// ----------------------------------------------------------------------------
// tb_axils_wr_ch
// Self-checking bench for axils_wr_ch: directed scenarios for reset, the
// basic write, data-before-address ordering, window miss, ack timeout,
// response back-pressure and mid-transaction reset, followed by randomized
// back-to-back transactions checked cycle by cycle against a reference model
// of the expected AXI/local-bus behaviour.
// ----------------------------------------------------------------------------
module tb_axils_wr_ch;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          ABITS = 12;
    localparam int          TMO   = 4;

    logic             ACLK = 1'b0;
    logic             ARESETn;
    logic             REG_WEN;
    logic [ABITS-1:0] REG_ADDR;
    logic [31:0]      REG_WDATA;
    logic [3:0]       REG_WSTRB;
    logic             REG_ACK;
    logic             REG_ERR;

    int checks   = 0;
    int failures = 0;

    axils_wr_ch_if axi ();

    axils_wr_ch #(
        .BASE_ADDR   (BASE),
        .ADDR_BITS   (ABITS),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .axi       (axi),
        .REG_WEN   (REG_WEN),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .REG_WSTRB (REG_WSTRB),
        .REG_ACK   (REG_ACK),
        .REG_ERR   (REG_ERR)
    );

    always #5 ACLK = ~ACLK;

    // Advance to just after the next rising edge; sampling and driving happen there.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic applyStimulus(input logic awv, input logic [31:0] addr,
                                 input logic wv, input logic [31:0] data,
                                 input logic [3:0] strb);
        axi.AWVALID = awv;
        axi.AWADDR  = addr;
        axi.AWPROT  = 3'($urandom);
        axi.WVALID  = wv;
        axi.WDATA   = data;
        axi.WSTRB   = strb;
    endtask

    task automatic test_reset();
        ARESETn    = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        axi.BREADY = 1'b0;
        REG_ACK    = 1'b0;
        REG_ERR    = 1'b0;
        tick();
        checks++;
        if (axi.AWREADY !== 1'b1 || axi.WREADY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: AWREADY=%b WREADY=%b, expected 1 1", axi.AWREADY, axi.WREADY);
        end
        tick();
        checks++;
        if (axi.BVALID !== 1'b0 || axi.BRESP !== 2'b00 || REG_WEN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: BVALID=%b BRESP=%b REG_WEN=%b, expected 0 00 0", axi.BVALID, axi.BRESP, REG_WEN);
        end
        checks++;
        if (REG_ADDR !== '0 || REG_WDATA !== 32'h0 || REG_WSTRB !== 4'h0) begin
            failures++;
            $display("[TB] FAIL reset_regbus: addr=%h data=%h strb=%h, expected 0 0 0", REG_ADDR, REG_WDATA, REG_WSTRB);
        end
        ARESETn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        applyStimulus(1'b1, BASE + 32'h10, 1'b1, 32'hA5A5_A5A5, 4'hF);
        tick();
        applyStimulus(1'b0, $urandom, 1'b0, $urandom, 4'h0);
        checks++;
        if (REG_WEN !== 1'b1 || REG_ADDR !== 12'h010 || REG_WDATA !== 32'hA5A5_A5A5 || REG_WSTRB !== 4'hF) begin
            failures++;
            $display("[TB] FAIL basic_wen: wen=%b addr=%h data=%h strb=%h, expected 1 010 a5a5a5a5 f", REG_WEN, REG_ADDR, REG_WDATA, REG_WSTRB);
        end
        checks++;
        if (axi.AWREADY !== 1'b0 || axi.WREADY !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_busy: AWREADY=%b WREADY=%b, expected 0 0", axi.AWREADY, axi.WREADY);
        end
        REG_ACK = 1'b1;
        REG_ERR = 1'b0;
        tick();
        REG_ACK = 1'b0;
        checks++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00 || REG_WEN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_resp: BVALID=%b BRESP=%b wen=%b, expected 1 00 0", axi.BVALID, axi.BRESP, REG_WEN);
        end
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
        checks++;
        if (axi.BVALID !== 1'b0 || axi.AWREADY !== 1'b1 || axi.WREADY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_done: BVALID=%b AWREADY=%b WREADY=%b, expected 0 1 1", axi.BVALID, axi.AWREADY, axi.WREADY);
        end
    endtask

    task automatic test_w_first();
        logic [31:0] d;
        d = $urandom;
        applyStimulus(1'b0, $urandom, 1'b1, d, 4'h3);
        tick();
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (axi.WREADY !== 1'b0 || axi.AWREADY !== 1'b1 || REG_WEN !== 1'b0) begin
                failures++;
                $display("[TB] FAIL wfirst_wait%0d: WREADY=%b AWREADY=%b wen=%b, expected 0 1 0", i, axi.WREADY, axi.AWREADY, REG_WEN);
            end
            applyStimulus(i == 3, BASE + 32'h0ABE, 1'b0, $urandom, 4'($urandom));
            tick();
        end
        applyStimulus(1'b0, $urandom, 1'b0, $urandom, 4'h0);
        checks++;
        if (REG_WEN !== 1'b1 || REG_ADDR !== 12'hABC || REG_WDATA !== d || REG_WSTRB !== 4'h3) begin
            failures++;
            $display("[TB] FAIL wfirst_wen: wen=%b addr=%h data=%h strb=%h, expected 1 abc %h 3", REG_WEN, REG_ADDR, REG_WDATA, REG_WSTRB, d);
        end
        REG_ACK = 1'b1;
        REG_ERR = 1'b1;
        tick();
        REG_ACK = 1'b0;
        REG_ERR = 1'b0;
        checks++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b10) begin
            failures++;
            $display("[TB] FAIL wfirst_slverr: BVALID=%b BRESP=%b, expected 1 10", axi.BVALID, axi.BRESP);
        end
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
    endtask

    task automatic test_miss();
        applyStimulus(1'b1, 32'h5000_0000, 1'b1, $urandom, 4'hF);
        tick();
        applyStimulus(1'b0, $urandom, 1'b0, $urandom, 4'h0);
        checks++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b11 || REG_WEN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL miss_decerr: BVALID=%b BRESP=%b wen=%b, expected 1 11 0", axi.BVALID, axi.BRESP, REG_WEN);
        end
        REG_ACK = 1'b1;
        REG_ERR = 1'b0;
        tick();
        REG_ACK = 1'b0;
        checks++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b11 || REG_WEN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL miss_stray_ack: BVALID=%b BRESP=%b wen=%b, expected 1 11 0", axi.BVALID, axi.BRESP, REG_WEN);
        end
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        n = 0;
        applyStimulus(1'b1, BASE + 32'h40, 1'b1, $urandom, 4'h5);
        tick();
        applyStimulus(1'b0, $urandom, 1'b0, $urandom, 4'h0);
        REG_ACK = 1'b0;
        for (int i = 0; i < 20 && axi.BVALID !== 1'b1; i++) begin
            if (REG_WEN === 1'b1) n++;
            REG_ERR = 1'($urandom);
            tick();
        end
        checks++;
        if (n != TMO) begin
            failures++;
            $display("[TB] FAIL timeout_len: REG_WEN high %0d cycles, expected %0d", n, TMO);
        end
        checks++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b10 || REG_WEN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_resp: BVALID=%b BRESP=%b wen=%b, expected 1 10 0", axi.BVALID, axi.BRESP, REG_WEN);
        end
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
        applyStimulus(1'b1, BASE + 32'h44, 1'b1, $urandom, 4'h8);
        tick();
        applyStimulus(1'b0, $urandom, 1'b0, $urandom, 4'h0);
        for (int i = 0; i < TMO; i++) begin
            REG_ACK = (i == TMO - 1);
            REG_ERR = 1'b0;
            tick();
        end
        REG_ACK = 1'b0;
        checks++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00 || REG_WEN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_ack_priority: BVALID=%b BRESP=%b wen=%b, expected 1 00 0", axi.BVALID, axi.BRESP, REG_WEN);
        end
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
    endtask

    task automatic test_bready_stall();
        applyStimulus(1'b1, BASE + 32'h100, 1'b1, $urandom, 4'hF);
        tick();
        applyStimulus(1'b0, $urandom, 1'b0, $urandom, 4'h0);
        REG_ACK = 1'b1;
        REG_ERR = 1'b1;
        tick();
        REG_ACK = 1'b0;
        REG_ERR = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b10 || axi.AWREADY !== 1'b0 || axi.WREADY !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: BVALID=%b BRESP=%b AWREADY=%b WREADY=%b, expected 1 10 0 0",
                         i, axi.BVALID, axi.BRESP, axi.AWREADY, axi.WREADY);
            end
            applyStimulus(1'b1, BASE + 32'h200, 1'b1, $urandom, 4'hF);
            REG_ACK    = 1'($urandom);
            axi.BREADY = 1'b0;
            tick();
        end
        applyStimulus(1'b0, $urandom, 1'b0, $urandom, 4'h0);
        REG_ACK    = 1'b0;
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
        checks++;
        if (axi.BVALID !== 1'b0 || axi.AWREADY !== 1'b1 || axi.WREADY !== 1'b1 || REG_WEN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_release: BVALID=%b AWREADY=%b WREADY=%b wen=%b, expected 0 1 1 0",
                     axi.BVALID, axi.AWREADY, axi.WREADY, REG_WEN);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        applyStimulus(1'b1, BASE + 32'h20, 1'b1, 32'h1234_5678, 4'hF);
        tick();
        applyStimulus(1'b0, $urandom, 1'b0, $urandom, 4'h0);
        checks++;
        if (REG_WEN !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_start: wen=%b, expected 1", REG_WEN);
        end
        ARESETn = 1'b0;
        tick();
        ARESETn = 1'b1;
        checks++;
        if (REG_WEN !== 1'b0 || axi.BVALID !== 1'b0 || REG_WDATA !== 32'h0 || REG_ADDR !== '0 || axi.AWREADY !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstmid_cleared: wen=%b BVALID=%b data=%h addr=%h AWREADY=%b, expected 0 0 0 0 1",
                     REG_WEN, axi.BVALID, REG_WDATA, REG_ADDR, axi.AWREADY);
        end
        for (int i = 0; i < 4; i++) begin
            REG_ACK    = 1'b1;
            axi.BREADY = 1'b1;
            tick();
            checks++;
            if (REG_WEN !== 1'b0 || axi.BVALID !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rstmid_silent%0d: wen=%b BVALID=%b, expected 0 0", i, REG_WEN, axi.BVALID);
            end
        end
        REG_ACK    = 1'b0;
        axi.BREADY = 1'b0;
        d = $urandom;
        applyStimulus(1'b1, BASE + 32'h24, 1'b1, d, 4'hC);
        tick();
        applyStimulus(1'b0, $urandom, 1'b0, $urandom, 4'h0);
        checks++;
        if (REG_WEN !== 1'b1 || REG_ADDR !== 12'h024 || REG_WDATA !== d || REG_WSTRB !== 4'hC) begin
            failures++;
            $display("[TB] FAIL rstmid_next_wen: wen=%b addr=%h data=%h strb=%h, expected 1 024 %h c", REG_WEN, REG_ADDR, REG_WDATA, REG_WSTRB, d);
        end
        REG_ACK = 1'b1;
        REG_ERR = 1'b0;
        tick();
        REG_ACK = 1'b0;
        checks++;
        if (axi.BVALID !== 1'b1 || axi.BRESP !== 2'b00) begin
            failures++;
            $display("[TB] FAIL rstmid_next_resp: BVALID=%b BRESP=%b, expected 1 00", axi.BVALID, axi.BRESP);
        end
        axi.BREADY = 1'b1;
        tick();
        axi.BREADY = 1'b0;
    endtask

    // Each transaction: pick delays and outcome, work out from the protocol
    // rules when every output should be high and with which values, then walk
    // the cycles comparing. The next transaction starts on the first IDLE cycle.
    task automatic test_random();
        logic [31:0]      addr, data;
        logic [3:0]       strb;
        logic             err, hit, wr;
        logic             exp_awr, exp_wr, exp_wen, exp_bv;
        logic [1:0]       resp;
        logic [ABITS-1:0] exp_addr;
        int               awd, wd, ackd, brd, t_hs, wenc, b0, bh;
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 2))
                0:       addr = BASE + ($urandom % (32'd1 << ABITS));
                1:       addr = BASE ^ (32'd1 << $urandom_range(ABITS, 31));
                default: addr = $urandom;
            endcase
            data = $urandom;
            strb = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            err  = 1'($urandom);
            awd  = $urandom_range(0, 3);
            wd   = $urandom_range(0, 3);
            ackd = $urandom_range(0, 5);
            brd  = $urandom_range(0, 5);

            hit  = ({32'd0, addr} >= {32'd0, BASE}) && ({32'd0, addr} < {32'd0, BASE} + (64'd1 << ABITS));
            wr   = hit && (strb != 4'h0);
            wenc = !wr ? 0 : (ackd < TMO) ? ackd + 1 : TMO;
            resp = !hit ? 2'b11 : !wr ? 2'b00 : (ackd >= TMO) ? 2'b10 : (err ? 2'b10 : 2'b00);
            exp_addr = ABITS'((addr % (32'd1 << ABITS)) / 32'd4 * 32'd4);
            t_hs = (awd > wd) ? awd : wd;
            b0   = t_hs + 1 + wenc;
            bh   = b0 + brd;

            for (int c = 0; c <= bh; c++) begin
                exp_awr = (c <= awd);
                exp_wr  = (c <= wd);
                exp_wen = (c > t_hs) && (c <= t_hs + wenc);
                exp_bv  = (c >= b0);
                checks++;
                if (axi.AWREADY !== exp_awr || axi.WREADY !== exp_wr) begin
                    failures++;
                    $display("[TB] FAIL rnd_ready t=%0d c=%0d: AWREADY=%b WREADY=%b, expected %b %b", t, c, axi.AWREADY, axi.WREADY, exp_awr, exp_wr);
                end
                checks++;
                if (REG_WEN !== exp_wen || axi.BVALID !== exp_bv) begin
                    failures++;
                    $display("[TB] FAIL rnd_ctrl t=%0d c=%0d: wen=%b BVALID=%b, expected %b %b", t, c, REG_WEN, axi.BVALID, exp_wen, exp_bv);
                end
                if (exp_wen) begin
                    checks++;
                    if (REG_ADDR !== exp_addr || REG_WDATA !== data || REG_WSTRB !== strb) begin
                        failures++;
                        $display("[TB] FAIL rnd_regbus t=%0d c=%0d: addr=%h data=%h strb=%h, expected %h %h %h",
                                 t, c, REG_ADDR, REG_WDATA, REG_WSTRB, exp_addr, data, strb);
                    end
                end
                if (exp_bv) begin
                    checks++;
                    if (axi.BRESP !== resp) begin
                        failures++;
                        $display("[TB] FAIL rnd_bresp t=%0d c=%0d: BRESP=%b, expected %b", t, c, axi.BRESP, resp);
                    end
                end
                applyStimulus(c == awd, (c == awd) ? addr : $urandom,
                              c == wd, (c == wd) ? data : $urandom,
                              (c == wd) ? strb : 4'($urandom));
                if (exp_wen) begin
                    REG_ACK = (c == t_hs + 1 + ackd);
                    REG_ERR = (c == t_hs + 1 + ackd) ? err : 1'($urandom);
                end else begin
                    REG_ACK = 1'($urandom);
                    REG_ERR = 1'($urandom);
                end
                axi.BREADY = (c < b0) ? 1'($urandom) : (c == bh);
                tick();
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        REG_ACK    = 1'b0;
        axi.BREADY = 1'b0;
        checks++;
        if (axi.AWREADY !== 1'b1 || axi.WREADY !== 1'b1 || axi.BVALID !== 1'b0 || REG_WEN !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rnd_final_idle: AWREADY=%b WREADY=%b BVALID=%b wen=%b, expected 1 1 0 0",
                     axi.AWREADY, axi.WREADY, axi.BVALID, REG_WEN);
        end
    endtask

    initial begin
        $display("[TB] starting axils_wr_ch bench");
        test_reset();
        test_basic();
        test_w_first();
        test_miss();
        test_timeout();
        test_bready_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog: still running at %0t, expected completion earlier", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
